layer_sequencer: RTL

Parametrised sequencer for the MNIST systolic accelerator. It drives the weight-memory address counters of NUM_LAYERS cascaded inner-product layers. Each layer starts when the previous one finishes, and a layer finishes when its weight stream returns the sentinel word. A host handshake (go/abort, busy/done/irq) and a runaway-length error make the block usable from the PicoRV32 peripheral without external glue.

---
 rtl/layer_sequencer_if.sv | 34 +++
 rtl/layer_sequencer.sv | 108 ++++++++++
 2 files changed

// File: rtl/layer_sequencer_if.sv
// Host/weight-memory bundle for layer_sequencer: handshake, per-layer weight
// words in, per-layer addresses and status out.
interface layer_sequencer_if #(
    parameter int NUM_LAYERS = 2,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 32
);
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic                         go;
    logic                         abort;
    logic [NUM_LAYERS*DATA_W-1:0] rdata;
    logic [NUM_LAYERS*CNT_W-1:0]  counter;
    logic [NUM_LAYERS-1:0]        layer_active;
    logic [NUM_LAYERS-1:0]        layer_start;
    logic [NUM_LAYERS-1:0]        layer_done;
    logic [LW-1:0]                cur_layer;
    logic                         busy;
    logic                         done;
    logic                         irq;
    logic                         error;

    modport master (
        output go, abort, rdata,
        input  counter, layer_active, layer_start, layer_done, cur_layer,
               busy, done, irq, error
    );

    modport slave (
        input  go, abort, rdata,
        output counter, layer_active, layer_start, layer_done, cur_layer,
               busy, done, irq, error
    );
endinterface

// File: rtl/layer_sequencer.sv
// Steps the weight-address counters of NUM_LAYERS cascaded layers; each layer
// runs until its weight stream returns SENTINEL, then hands off to the next.
module layer_sequencer #(
    parameter int                NUM_LAYERS = 2,
    parameter int                DATA_W     = 32,
    parameter int                CNT_W      = 32,
    parameter logic [DATA_W-1:0] SENTINEL   = 32'h7fffffff,
    parameter int                MAX_LEN    = 1024
) (
    input logic              clk,
    input logic              reset,
    layer_sequencer_if.slave bus
);
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [LW-1:0]    LAST_LAYER = LW'(NUM_LAYERS - 1);
    localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(MAX_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    state_t                state;
    logic [LW-1:0]         cur;
    logic [CNT_W-1:0]      cnt [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] active_q, start_q, done_q;
    logic                  busy_q, done_lvl_q, irq_q, error_q;
    logic                  hit;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit = 1'b0;
        if (state == RUN)
            hit = (bus.rdata[cur*DATA_W +: DATA_W] == SENTINEL);
    end

    // abort shares the reset path so it overrides go and a same-cycle sentinel.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= only; = here would create ordering races.
        if (reset || bus.abort) begin
            state      <= IDLE;
            cur        <= '0;
            active_q   <= '0;
            start_q    <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            done_lvl_q <= 1'b0;
            irq_q      <= 1'b0;
            error_q    <= 1'b0;
            // NOTE: the per-layer counters are few flops, so they are reset
            // explicitly rather than treated as unreset storage.
            for (int l = 0; l < NUM_LAYERS; l++) cnt[l] <= '0;
        end else begin
            irq_q   <= 1'b0;
            start_q <= '0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (bus.go) begin
                        state      <= RUN;
                        cur        <= '0;
                        active_q   <= NUM_LAYERS'(1);
                        start_q    <= NUM_LAYERS'(1);
                        done_q     <= '0;
                        busy_q     <= 1'b1;
                        done_lvl_q <= 1'b0;
                        error_q    <= 1'b0;
                        for (int l = 0; l < NUM_LAYERS; l++) cnt[l] <= '0;
                    end
                end
                RUN: begin
                    if (hit) begin
                        done_q[cur] <= 1'b1;
                        if (cur == LAST_LAYER) begin
                            state      <= DONE;
                            active_q   <= '0;
                            busy_q     <= 1'b0;
                            done_lvl_q <= 1'b1;
                            irq_q      <= 1'b1;
                        end else begin
                            cur      <= cur + 1'b1;
                            active_q <= NUM_LAYERS'(1) << (cur + 1'b1);
                            start_q  <= NUM_LAYERS'(1) << (cur + 1'b1);
                        end
                    end else if (cnt[cur] == LAST_ADDR) begin
                        state    <= ERR;
                        active_q <= '0;
                        busy_q   <= 1'b0;
                        error_q  <= 1'b1;
                        irq_q    <= 1'b1;
                    end else begin
                        cnt[cur] <= cnt[cur] + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_pack
        assign bus.counter[g*CNT_W +: CNT_W] = cnt[g];
    end

    assign bus.layer_active = active_q;
    assign bus.layer_start  = start_q;
    assign bus.layer_done   = done_q;
    assign bus.cur_layer    = cur;
    assign bus.busy         = busy_q;
    assign bus.done         = done_lvl_q;
    assign bus.irq          = irq_q;
    assign bus.error        = error_q;
endmodule
